dcim_bitserial_feeder: RTL and testbench

//  Upstream feeder for the DCIM bit-serial MAC stage. Holds four 32-element weight rows and

---
 rtl/dcim_bitserial_feeder.sv | 129 ++++++++++++
 tb/tb_dcim_bitserial_feeder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcim_bitserial_feeder.sv
// Bit-serial feeder for the DCIM MAC stage: four weight rows, one activation vector at a
// time, emitted as four MSB-first bit-planes of activation-masked weight nibbles.
module dcim_bitserial_feeder (
  input  logic         clk,
  input  logic         rst,
  input  logic         w_load,
  input  logic [1:0]   w_row,
  input  logic [127:0] w_data,
  output logic         w_err,
  input  logic         act_valid,
  output logic         act_ready,
  input  logic [127:0] act_data,
  output logic         out_valid,
  output logic [127:0] out_data1,
  output logic [127:0] out_data2,
  output logic [127:0] out_data3,
  output logic [127:0] out_data4,
  output logic         busy
);

  localparam int unsigned N_ELEM = 32;
  localparam int unsigned W_BITS = 4;
  localparam int unsigned A_BITS = 4;
  localparam int unsigned N_ROWS = 4;
  localparam int unsigned VEC_W  = N_ELEM * W_BITS;
  localparam int unsigned BIT_W  = 2;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(A_BITS - 1);

  logic [0:0]                       r_state;
  logic [BIT_W-1:0]                 r_bit;
  logic [VEC_W-1:0]                 r_act;
  logic [N_ROWS-1:0][VEC_W-1:0]     r_w;
  logic [N_ROWS-1:0][VEC_W-1:0]     r_out;
  logic                             r_out_valid;
  logic                             r_w_err;

  logic [0:0]                       w_nxt_state;
  logic [BIT_W-1:0]                 w_nxt_bit;
  logic                             w_load_act;
  logic                             w_wr_ok;
  logic                             w_accept;
  logic [A_BITS-1:0]                w_nib;
  logic [N_ROWS-1:0][VEC_W-1:0]     w_plane;

  // Weight writes and new vectors are only safe on a vector boundary.
  assign w_wr_ok   = (r_state == ST_IDLE) || (r_bit == '0);
  assign act_ready = !w_load && w_wr_ok;
  assign w_accept  = act_valid && act_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_bit   <= LAST_BIT;
    end else begin
      r_state <= w_nxt_state;
      r_bit   <= w_nxt_bit;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_bit   = r_bit;
    w_load_act  = 1'b0;
    if (r_state == ST_IDLE) begin
      if (w_accept) begin
        w_nxt_state = ST_SHIFT;
        w_nxt_bit   = LAST_BIT;
        w_load_act  = 1'b1;
      end
    end else begin
      w_nxt_bit = r_bit - BIT_W'(1);
      if (r_bit == '0) begin
        if (w_accept) begin
          w_nxt_bit  = LAST_BIT;
          w_load_act = 1'b1;
        end else begin
          w_nxt_state = ST_IDLE;
        end
      end
    end
  end

  // Each weight nibble passes through when its activation's current bit is set.
  always_comb begin
    w_plane = '0;
    w_nib   = '0;
    for (int r = 0; r < int'(N_ROWS); r++) begin
      for (int j = 0; j < int'(N_ELEM); j++) begin
        w_nib = r_act[j*A_BITS +: A_BITS];
        if (w_nib[r_bit]) begin
          w_plane[r][j*W_BITS +: W_BITS] = r_w[r][j*W_BITS +: W_BITS];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_act       <= '0;
      r_w         <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_w_err     <= 1'b0;
    end else begin
      if (w_load_act) begin
        r_act <= act_data;
      end
      if (w_load && w_wr_ok) begin
        r_w[w_row] <= w_data;
      end
      r_w_err     <= w_load && !w_wr_ok;
      r_out_valid <= (r_state == ST_SHIFT);
      r_out       <= (r_state == ST_SHIFT) ? w_plane : '0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data1 = r_out[0];
  assign out_data2 = r_out[1];
  assign out_data3 = r_out[2];
  assign out_data4 = r_out[3];
  assign w_err     = r_w_err;
  assign busy      = (r_state == ST_SHIFT);

endmodule

// File: tb/tb_dcim_bitserial_feeder.sv
// Bench for dcim_bitserial_feeder: a queue-of-beats reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_dcim_bitserial_feeder;

  typedef logic [3:0][127:0] plane_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         w_load;
  logic [1:0]   w_row;
  logic [127:0] w_data;
  logic         w_err;
  logic         act_valid;
  logic         act_ready;
  logic [127:0] act_data;
  logic         out_valid;
  logic [127:0] out_data1, out_data2, out_data3, out_data4;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  plane_t m_w;
  plane_t m_q[$];
  plane_t exp_data;
  logic   exp_valid;
  logic   exp_err;
  int     m_sz;

  localparam logic [127:0] ALL_F = {32{4'hF}};

  always #5 clk = ~clk;

  dcim_bitserial_feeder dut (
    .clk(clk), .rst(rst), .w_load(w_load), .w_row(w_row), .w_data(w_data), .w_err(w_err),
    .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
    .out_valid(out_valid), .out_data1(out_data1), .out_data2(out_data2),
    .out_data3(out_data3), .out_data4(out_data4), .busy(busy)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Plane b of a vector: weight nibble j kept iff bit b of activation j is set.
  function automatic plane_t planes(input logic [127:0] a, input int b);
    plane_t p;
    p = '0;
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 32; j++)
        if (a[4*j+b]) p[r][4*j +: 4] = m_w[r][4*j +: 4];
    return p;
  endfunction

  function automatic int nibsum(input logic [127:0] v);
    int s;
    s = 0;
    for (int j = 0; j < 32; j++) s += int'(v[4*j +: 4]);
    return s;
  endfunction

  // Reference model: each accepted vector becomes four queued beats, popped one per edge.
  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_w       = '0;
      exp_valid = 1'b0;
      exp_data  = '0;
      exp_err   = 1'b0;
    end else begin
      m_sz = m_q.size();
      if (m_sz > 0) begin
        exp_data  = m_q.pop_front();
        exp_valid = 1'b1;
      end else begin
        exp_data  = '0;
        exp_valid = 1'b0;
      end
      exp_err = w_load && (m_sz > 1);
      if (act_valid && !w_load && m_sz <= 1)
        for (int b = 3; b >= 0; b--) m_q.push_back(planes(act_data, b));
      if (w_load && m_sz <= 1) m_w[w_row] = w_data;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_out_valid", 128'(out_valid), 128'(exp_valid));
      chk("m_out_data1", out_data1, exp_data[0]);
      chk("m_out_data2", out_data2, exp_data[1]);
      chk("m_out_data3", out_data3, exp_data[2]);
      chk("m_out_data4", out_data4, exp_data[3]);
      chk("m_w_err", 128'(w_err), 128'(exp_err));
      chk("m_busy", 128'(busy), 128'(m_q.size() != 0));
      chk("m_act_ready", 128'(act_ready), 128'(!w_load && m_q.size() <= 1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [1:0] row, input logic [127:0] d);
    w_load = 1'b1; w_row = row; w_data = d;
    tick();
    w_load = 1'b0;
  endtask

  task automatic send(input logic [127:0] a);
    act_valid = 1'b1; act_data = a;
    tick();
    act_valid = 1'b0;
  endtask

  task automatic run_e2e(output int acc [4]);
    plane_t o;
    for (int r = 0; r < 4; r++) acc[r] = 0;
    for (int b = 0; b < 4; b++) begin
      tick();
      o = {out_data4, out_data3, out_data2, out_data1};
      for (int r = 0; r < 4; r++) acc[r] = acc[r] * 2 + nibsum(o[r]);
    end
  endtask

  initial begin
    int acc [4];
    int n_acc, beats, rises;
    logic prev;
    logic [127:0] exp_v;

    rst = 1'b1; w_load = 1'b0; w_row = '0; w_data = '0; act_valid = 1'b0; act_data = '0;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_out_data1", out_data1, 128'(0));
    chk("rst_act_ready", 128'(act_ready), 128'(1));
    rst = 1'b0;

    // Plane order: MSB first, act 0101 -> 0, F, 0, F
    wr(2'd0, ALL_F);
    send({32{4'h5}});
    for (int b = 0; b < 4; b++) begin
      tick();
      exp_v = (b % 2 == 1) ? ALL_F : 128'(0);
      chk("order_valid", 128'(out_valid), 128'(1));
      chk("order_data1", out_data1, exp_v);
      chk("order_data2", out_data2, 128'(0));
    end
    tick();
    chk("order_end_valid", 128'(out_valid), 128'(0));

    // Reset mid-vector aborts it and clears weights
    wr(2'd1, rand128());
    send(ALL_F);
    tick(); tick();
    rst = 1'b1;
    tick(); tick();
    chk("midrst_valid", 128'(out_valid), 128'(0));
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_data1", out_data1, 128'(0));
    rst = 1'b0;
    send(ALL_F);
    for (int b = 0; b < 4; b++) begin
      tick();
      chk("clr_valid", 128'(out_valid), 128'(1));
      chk("clr_data1", out_data1, 128'(0));
      chk("clr_data2", out_data2, 128'(0));
    end
    tick();

    // End-to-end sums seen by the downstream accumulator
    wr(2'd0, {32{4'h1}});
    wr(2'd1, {32{4'h2}});
    wr(2'd2, {32{4'h3}});
    wr(2'd3, {32{4'h4}});
    send(ALL_F);
    run_e2e(acc);
    chk("e2e_o1", 128'(acc[0]), 128'(480));
    chk("e2e_o2", 128'(acc[1]), 128'(960));
    chk("e2e_o3", 128'(acc[2]), 128'(1440));
    chk("e2e_o4", 128'(acc[3]), 128'(1920));
    tick();

    // Weight collisions: mid-vector write dropped, boundary write deferred
    send(ALL_F);
    tick();
    w_load = 1'b1; w_row = 2'd0; w_data = {32{4'h7}};
    tick();
    w_load = 1'b0;
    chk("coll_err_pulse", 128'(w_err), 128'(1));
    tick();
    chk("coll_err_clear", 128'(w_err), 128'(0));
    w_load = 1'b1; w_row = 2'd1; w_data = {32{4'h5}};
    act_valid = 1'b1; act_data = ALL_F;
    #1;
    chk("coll_ready_low", 128'(act_ready), 128'(0));
    tick();
    w_load = 1'b0; act_valid = 1'b0;
    chk("coll_old_w_plane", out_data2, {32{4'h2}});
    chk("coll_no_accept", 128'(busy), 128'(0));
    chk("coll_no_err", 128'(w_err), 128'(0));
    tick();
    chk("coll_idle", 128'(out_valid), 128'(0));
    send(ALL_F);
    run_e2e(acc);
    chk("coll_row0_kept", 128'(acc[0]), 128'(480));
    chk("coll_row1_new", 128'(acc[1]), 128'(2400));
    chk("coll_row2", 128'(acc[2]), 128'(1440));
    tick();

    // Back-to-back: three vectors, valid held high -> 12 contiguous beats
    n_acc = 0; beats = 0; rises = 0; prev = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (n_acc < 3) begin
        act_valid = 1'b1; act_data = rand128();
        #1;
        if (act_ready) n_acc++;
      end else begin
        act_valid = 1'b0;
      end
      tick();
      if (out_valid) beats++;
      if (out_valid && !prev) rises++;
      prev = out_valid;
    end
    act_valid = 1'b0;
    chk("b2b_accepts", 128'(n_acc), 128'(3));
    chk("b2b_beats", 128'(beats), 128'(12));
    chk("b2b_contiguous", 128'(rises), 128'(1));

    // Idle: no activations offered
    for (int c = 0; c < 20; c++) begin
      act_data = rand128();
      tick();
      chk("idle_valid", 128'(out_valid), 128'(0));
      chk("idle_data1", out_data1, 128'(0));
      chk("idle_data4", out_data4, 128'(0));
    end

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      act_valid = $urandom_range(0, 1) == 1;
      act_data  = rand128();
      w_load    = ($urandom_range(0, 9) == 0);
      w_row     = 2'($urandom_range(0, 3));
      w_data    = rand128();
      tick();
    end
    rst = 1'b0; act_valid = 1'b0; w_load = 1'b0;
    for (int c = 0; c < 8; c++) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
